alu_req_scheduler: RTL
======================

ALU_REQ_SCHEDULER -- requirements
Module: alu_req_scheduler

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width; the result width is 2*WIDTH.
REQ-002 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 Ports reqN_valid in 1, reqN_ready out 1, reqN_opcode in 4, reqN_a in WIDTH, reqN_b in WIDTH, reqN_last in 1 (N=0,1) SHALL form two requester command channels.
REQ-006 Ports alu_a out WIDTH, alu_b out WIDTH, alu_opcode out 4, alu_enable out 1, alu_mac_clr out 1 SHALL drive the shared ALU.
REQ-007 Ports alu_result in 2*WIDTH, alu_carry in 1, alu_borrow in 1, alu_zero in 1 SHALL return ALU outputs.
REQ-008 Ports resp_valid out 1, resp_ready in 1, resp_id out 1, resp_result out 2*WIDTH, resp_carry out 1, resp_borrow out 1, resp_zero out 1 SHALL form the response channel.
REQ-009 Port busy out 1 SHALL be high whenever the state is not IDLE.

Function
REQ-010 Transfers SHALL occur on valid&&ready; valid, once high, may not be assumed held by the scheduler.
REQ-011 FSM states SHALL be IDLE, EXEC, MAC_CLR, MAC_RUN, MAC_DRAIN, RESP.
REQ-012 In IDLE, exactly one reqN_ready SHALL be high: the round-robin winner among valid requesters, or the pointer's favoured requester if none is valid.
REQ-013 The round-robin pointer SHALL move to the other requester when a response completes; it SHALL favour req0 after reset.
REQ-014 A non-MAC command (opcode != 4'b1000) accepted in cycle T SHALL be registered, drive alu_* with alu_enable=0 in T+1 (EXEC), and be captured at the end of T+1; resp_valid rises in T+2.
REQ-015 A MAC command accepted in IDLE SHALL lock the grant to that requester until its response completes; the beat is registered and the state goes to MAC_CLR.
REQ-016 MAC_CLR SHALL last one cycle with alu_mac_clr=1, alu_enable=0, all reqN_ready=0.
REQ-017 In MAC_RUN, alu_enable SHALL be 1 in exactly those cycles where a registered beat is valid, driving that beat's alu_a/alu_b with alu_opcode=4'b1000.
REQ-018 In MAC_RUN, the locked requester's ready SHALL be 1 until its last beat is accepted, giving one beat per cycle; the other ready SHALL be 0.
REQ-019 Opcodes of subsequent beats in a burst SHALL be ignored (treated as MAC).
REQ-020 A requester de-asserting valid mid-burst SHALL cause alu_enable=0 bubbles without losing the lock.
REQ-021 After the last beat's enable cycle, the FSM SHALL enter MAC_DRAIN for one cycle and capture alu_result/flags; N back-to-back beats accepted from cycle T produce resp_valid at T+N+3.
REQ-022 A first beat with last=1 SHALL be a valid 1-beat burst.
REQ-023 In RESP, resp_* SHALL hold stable until resp_ready; on handshake, the FSM returns to IDLE and the pointer updates; all reqN_ready=0 in RESP.
REQ-024 resp_id SHALL be the index of the served requester.
REQ-025 Undefined opcode 4'b1111 SHALL be issued as a normal non-MAC op; the captured result is taken from the ALU unmodified.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, pointer to req0, lock clear, beat-valid 0, all alu_* outputs 0, resp_* outputs 0, busy 0.
REQ-027 Reset asserted mid-burst or mid-response SHALL discard the operation with no response.

Structure
REQ-028 Package alu_ctrl_pkg SHALL hold the 4-bit opcode constants (OP_ADD=0000 .. OP_MAC=1000 .. OP_TANH=1110) and the FSM state type.
REQ-029 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-030 req0 ADD a=200 b=100 -> resp_valid 2 cycles after accept, resp_result=0x002C, resp_carry=1, resp_id=0.
REQ-031 Both valid in the same cycle after reset, each a single op -> req0 served first, then req1; the next simultaneous pair is served req0 first again because the pointer flips after each response.
REQ-032 req0 MAC burst (2,3),(4,5),(1,1,last) back-to-back -> one alu_mac_clr pulse, alu_enable high for 3 cycles, resp_result=0x001B at T+6.
REQ-033 req1 valid throughout req0's MAC burst -> req1_ready stays 0 until req0's response handshake; req1 is granted in the next IDLE.
REQ-034 resp_ready held low for 5 cycles -> resp_* stable, no new grant, busy=1.
REQ-035 rst_n pulsed low during MAC_RUN -> all outputs 0 asynchronously, no response, the next command is served normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, scheduler state type and small decode helpers
// for the ALU request scheduler.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_MAC  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MOD  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_NOT  = 4'b1100;
  localparam logic [3:0] OP_RELU = 4'b1101;
  localparam logic [3:0] OP_TANH = 4'b1110;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MAC_CLR,
    MAC_RUN,
    MAC_DRAIN,
    RESP
  } state_t;

  function automatic logic is_mac(input logic [3:0] op);
    return op == OP_MAC;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves away from the requester just
// served when its response completes, and favours req0 out of reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant
);

  logic ptr;

  // Favoured requester wins unless it is idle and the other one is asking.
  always_comb begin
    grant = ptr;
    if (!req[ptr] && req[!ptr]) grant = !ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= !served;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters: single ops respond 2 cycles after accept,
// MAC bursts lock the grant until their response; resp_* holds until resp_ready.
module alu_req_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req0_last,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_opcode,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic               req1_last,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_opcode,
  output logic               alu_enable,
  output logic               alu_mac_clr,
  input  logic [2*WIDTH-1:0] alu_result,
  input  logic               alu_carry,
  input  logic               alu_borrow,
  input  logic               alu_zero,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_result,
  output logic               resp_carry,
  output logic               resp_borrow,
  output logic               resp_zero,
  output logic               busy
);

  state_t state, state_nxt;

  logic             grant, sel, rdy, accept, resp_fire;
  logic             id_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             beat_vld, beat_last, last_acc;

  logic             in_valid, in_last;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (resp_fire),
    .served (id_q),
    .grant  (grant)
  );

  // Outside IDLE the locked requester is the only one that can be looked at.
  assign sel      = (state == IDLE) ? grant : id_q;
  assign in_valid = sel ? req1_valid  : req0_valid;
  assign in_op    = sel ? req1_opcode : req0_opcode;
  assign in_a     = sel ? req1_a      : req0_a;
  assign in_b     = sel ? req1_b      : req0_b;
  assign in_last  = sel ? req1_last   : req0_last;

  assign req0_ready = rdy && !sel;
  assign req1_ready = rdy && sel;
  assign accept     = rdy && in_valid;
  assign resp_valid = (state == RESP);
  assign resp_fire  = resp_valid && resp_ready;
  assign busy       = (state != IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;

  always_comb begin
    state_nxt   = state;
    rdy         = 1'b0;
    alu_enable  = 1'b0;
    alu_mac_clr = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (accept) state_nxt = is_mac(in_op) ? MAC_CLR : EXEC;
      end
      EXEC:    state_nxt = RESP;
      MAC_CLR: begin
        alu_mac_clr = 1'b1;
        state_nxt   = MAC_RUN;
      end
      MAC_RUN: begin
        rdy        = !last_acc;
        alu_enable = beat_vld;
        if (beat_vld && beat_last) state_nxt = MAC_DRAIN;
      end
      MAC_DRAIN: state_nxt = RESP;
      RESP:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      beat_vld    <= 1'b0;
      beat_last   <= 1'b0;
      last_acc    <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_borrow <= 1'b0;
      resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        a_q       <= in_a;
        b_q       <= in_b;
        beat_last <= in_last;
        last_acc  <= in_last;
        // Later burst beats keep the MAC opcode latched by the first beat.
        if (state == IDLE) begin
          id_q     <= sel;
          op_q     <= in_op;
          beat_vld <= is_mac(in_op);
        end else begin
          beat_vld <= 1'b1;
        end
      end else if (state == MAC_RUN) begin
        beat_vld <= 1'b0;
      end
      if (state == EXEC || state == MAC_DRAIN) begin
        resp_id     <= id_q;
        resp_result <= alu_result;
        resp_carry  <= alu_carry;
        resp_borrow <= alu_borrow;
        resp_zero   <= alu_zero;
      end
    end
  end

endmodule
